// File: rtl/hash_pkg.sv
// Shared encodings for the hash front end: SHA type codes, scheduler states, tuser field position.
package hash_pkg;

    localparam logic [1:0] SHA224 = 2'b00;
    localparam logic [1:0] SHA256 = 2'b01;
    localparam logic [1:0] SHA384 = 2'b10;
    localparam logic [1:0] SHA512 = 2'b11;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_SETUP       = 3'd1;
    localparam logic [2:0] ST_STREAM      = 3'd2;
    localparam logic [2:0] ST_WAIT_DIGEST = 3'd3;
    localparam logic [2:0] ST_FLUSH       = 3'd4;

    localparam int TUSER_SHA_TYPE_LSB = 0;

    typedef enum logic [2:0] {
        IDLE        = ST_IDLE,
        SETUP       = ST_SETUP,
        STREAM      = ST_STREAM,
        WAIT_DIGEST = ST_WAIT_DIGEST,
        FLUSH       = ST_FLUSH
    } sched_state_t;

endpackage

// File: rtl/hash_watchdog.sv
// Digest watchdog: counts enabled cycles since clear; expire is combinational from the count
// and is high on the TIMEOUT_CYCLES-th enabled cycle. No backpressure.
module hash_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/hash_scheduler.sv
// Message scheduler in front of hash_engine: latches sha_type, gates one message at a time.
// Zero-latency pass-through in STREAM (ready/valid combinational); host held off outside STREAM.
module hash_scheduler
    import hash_pkg::*;
#(
    parameter int S_AXIS_DATA_WIDTH  = 512,
    parameter int S_AXIS_TUSER_WIDTH = 128,
    parameter int TIMEOUT_CYCLES     = 4096
) (
    input  logic                            axi_aclk,
    input  logic                            axi_reset,
    input  logic [S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic [S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    input  logic                            d_axis_tvalid,
    input  logic                            d_axis_tready,
    input  logic                            d_axis_tlast,
    output logic [1:0]                      sha_type,
    output logic                            en,
    output logic                            busy,
    output logic                            timeout_err,
    output logic [31:0]                     msg_count,
    output logic [15:0]                     err_count
);

    sched_state_t state;
    logic         in_stream;
    logic         last_beat;
    logic         digest_done;
    logic         wd_expire;

    assign in_stream   = (state == STREAM);
    assign last_beat   = in_stream && s_axis_tvalid && m_axis_tready && s_axis_tlast;
    assign digest_done = d_axis_tvalid && d_axis_tready && d_axis_tlast;

    assign m_axis_tvalid = in_stream && s_axis_tvalid;
    assign s_axis_tready = in_stream && m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;

    hash_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (axi_aclk),
        .rst    (axi_reset),
        .clear  (last_beat),
        .enable (state == WAIT_DIGEST),
        .expire (wd_expire)
    );

    // en/busy are registered, so they are loaded with the value for the state being entered.
    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state       <= IDLE;
            en          <= 1'b0;
            busy        <= 1'b0;
            sha_type    <= SHA224;
            timeout_err <= 1'b0;
            msg_count   <= '0;
            err_count   <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_axis_tvalid) begin
                        sha_type <= s_axis_tuser[TUSER_SHA_TYPE_LSB +: 2];
                        en       <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (last_beat) begin
                        state <= WAIT_DIGEST;
                    end
                end
                WAIT_DIGEST: begin
                    // A digest landing on the expiry cycle still counts as a success.
                    if (digest_done) begin
                        msg_count <= msg_count + 32'd1;
                        en        <= 1'b0;
                        state     <= FLUSH;
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                        en    <= 1'b0;
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_scheduler.sv
// Directed bench for hash_scheduler with narrow buses and a 16-cycle digest watchdog.
module tb_hash_scheduler;

    localparam int DW = 32;
    localparam int UW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_tdata;
    logic [UW-1:0]   s_tuser;
    logic [DW/8-1:0] s_tkeep;
    logic            s_tvalid;
    logic            s_tready;
    logic            s_tlast;
    logic [DW-1:0]   m_tdata;
    logic [UW-1:0]   m_tuser;
    logic [DW/8-1:0] m_tkeep;
    logic            m_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic            d_vld;
    logic            d_rdy;
    logic            d_last;
    logic [1:0]      sha_type;
    logic            en;
    logic            busy;
    logic            timeout_err;
    logic [31:0]     msg_count;
    logic [15:0]     err_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hash_scheduler #(
        .S_AXIS_DATA_WIDTH (DW),
        .S_AXIS_TUSER_WIDTH(UW),
        .TIMEOUT_CYCLES    (TO)
    ) dut (
        .axi_aclk     (clk),
        .axi_reset    (rst),
        .s_axis_tdata (s_tdata),
        .s_axis_tuser (s_tuser),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tuser (m_tuser),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tlast (m_tlast),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .d_axis_tvalid(d_vld),
        .d_axis_tready(d_rdy),
        .d_axis_tlast (d_last),
        .sha_type     (sha_type),
        .en           (en),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .msg_count    (msg_count),
        .err_count    (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven and outputs sampled 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_en", en, 0);
        check("rst_sha", sha_type, 0);
        check("rst_s_rdy", s_tready, 0);
        check("rst_m_vld", m_tvalid, 0);
        check("rst_tmo", timeout_err, 0);
        check("rst_msg", msg_count, 0);
        check("rst_err", err_count, 0);
        rst = 1'b0;
    endtask

    task automatic digest();
        d_vld = 1'b1; d_rdy = 1'b1; d_last = 1'b1;
        tick();
        d_vld = 1'b0; d_rdy = 1'b0; d_last = 1'b0;
        #1;
    endtask

    initial begin
        int beat;
        logic tog;

        rst = 1'b1; s_tdata = '0; s_tuser = '0; s_tkeep = '1; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b0; d_vld = 1'b0; d_rdy = 1'b0; d_last = 1'b0;

        // Single-beat SHA-256 message; stray digest in IDLE must be ignored
        do_reset();
        digest();
        check("idle_snoop_msg", msg_count, 0);
        check("idle_snoop_busy", busy, 0);
        s_tvalid = 1'b1; s_tuser = 8'h01; s_tdata = 32'hA5A5_0001; s_tkeep = 4'hC; s_tlast = 1'b1;
        m_tready = 1'b1;
        #1;
        check("idle_s_rdy", s_tready, 0);
        check("idle_m_vld", m_tvalid, 0);
        tick();
        check("setup_en", en, 1);
        check("setup_sha", sha_type, 2'b01);
        check("setup_m_vld", m_tvalid, 0);
        tick();
        check("stream_m_vld", m_tvalid, 1);
        check("stream_s_rdy", s_tready, 1);
        check("stream_dat", m_tdata, 32'hA5A5_0001);
        check("stream_keep", m_tkeep, 4'hC);
        check("stream_last", m_tlast, 1);
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        #1;
        check("wait_s_rdy", s_tready, 0);
        check("wait_m_vld", m_tvalid, 0);
        check("wait_en", en, 1);
        digest();
        check("flush_msg", msg_count, 1);
        check("flush_en", en, 0);
        check("flush_busy", busy, 1);
        tick();
        check("idle_busy", busy, 0);
        check("idle_en", en, 0);

        // 4-beat SHA-512 with toggling engine ready; tuser drops to 00 from the third beat
        do_reset();
        s_tvalid = 1'b1; s_tuser = 8'h03; s_tdata = 32'h100; s_tlast = 1'b0; m_tready = 1'b1;
        tick();
        tick();
        beat = 0;
        tog = 1'b1;
        for (int c = 0; c < 20 && beat < 4; c++) begin
            s_tdata  = 32'h100 + beat;
            s_tuser  = (beat >= 2) ? 8'h00 : 8'h03;
            s_tlast  = (beat == 3);
            m_tready = tog;
            #1;
            check("b4_s_rdy_mirror", s_tready, m_tready);
            check("b4_m_vld", m_tvalid, 1);
            if (m_tvalid && m_tready) begin
                check("b4_fwd_dat", m_tdata, 32'h100 + beat);
                check("b4_fwd_user", m_tuser, (beat >= 2) ? 8'h00 : 8'h03);
                beat++;
            end
            tog = ~tog;
            tick();
        end
        check("b4_beats", beat, 4);
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        #1;
        check("b4_sha_held", sha_type, 2'b11);
        check("b4_wait_m_vld", m_tvalid, 0);
        digest();
        check("b4_msg", msg_count, 1);

        // Back-to-back: second message presented as soon as the first tlast is taken
        do_reset();
        s_tvalid = 1'b1; s_tuser = 8'h00; s_tdata = 32'hB0; s_tlast = 1'b1; m_tready = 1'b1;
        tick();
        tick();
        check("b2b_first_dat", m_tdata, 32'hB0);
        check("b2b_first_sha", sha_type, 2'b00);
        tick();
        s_tuser = 8'h02; s_tdata = 32'hB1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("b2b_wait_s_rdy", s_tready, 0);
            tick();
        end
        digest();
        check("b2b_flush_s_rdy", s_tready, 0);
        check("b2b_flush_msg", msg_count, 1);
        tick();
        check("b2b_idle_s_rdy", s_tready, 0);
        check("b2b_idle_busy", busy, 0);
        tick();
        check("b2b_setup_sha", sha_type, 2'b10);
        check("b2b_setup_s_rdy", s_tready, 0);
        tick();
        check("b2b_stream_s_rdy", s_tready, 1);
        check("b2b_stream_dat", m_tdata, 32'hB1);
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        #1;
        digest();
        check("b2b_msg", msg_count, 2);

        // Watchdog expiry with no digest
        do_reset();
        s_tvalid = 1'b1; s_tuser = 8'h01; s_tdata = 32'hC0; s_tlast = 1'b1; m_tready = 1'b1;
        tick();
        tick();
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        for (int i = 1; i < TO; i++) begin
            check("to_quiet", timeout_err, 0);
            tick();
        end
        check("to_c16_quiet", timeout_err, 0);
        check("to_c16_en", en, 1);
        tick();
        check("to_pulse", timeout_err, 1);
        check("to_err", err_count, 1);
        check("to_msg", msg_count, 0);
        check("to_flush_en", en, 0);
        check("to_flush_busy", busy, 1);
        tick();
        check("to_pulse_end", timeout_err, 0);
        check("to_idle_busy", busy, 0);

        // Digest exactly on the last watchdog cycle; a non-tlast digest beat earlier holds state
        do_reset();
        s_tvalid = 1'b1; s_tuser = 8'h02; s_tdata = 32'hD0; s_tlast = 1'b1; m_tready = 1'b1;
        tick();
        tick();
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        for (int i = 1; i < TO; i++) begin
            d_vld = (i == 3); d_rdy = (i == 3); d_last = 1'b0;
            check("edge_hold_en", en, 1);
            tick();
        end
        d_vld = 1'b0; d_rdy = 1'b0;
        digest();
        check("edge_msg", msg_count, 1);
        check("edge_err", err_count, 0);
        check("edge_tmo", timeout_err, 0);
        check("edge_flush_en", en, 0);

        // Reset during STREAM after two of four beats, then a fresh message
        s_tvalid = 1'b1; s_tuser = 8'h03; s_tdata = 32'hE0; s_tlast = 1'b0; m_tready = 1'b1;
        tick();
        tick();
        tick();
        tick();
        tick();
        check("mid_sha", sha_type, 2'b11);
        check("mid_s_rdy", s_tready, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_en", en, 0);
        check("mid_rst_s_rdy", s_tready, 0);
        check("mid_rst_msg", msg_count, 0);
        check("mid_rst_sha", sha_type, 0);
        rst = 1'b0;
        s_tuser = 8'h02; s_tdata = 32'hF0; s_tlast = 1'b1;
        tick();
        check("fresh_sha", sha_type, 2'b10);
        tick();
        check("fresh_dat", m_tdata, 32'hF0);
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
        #1;
        digest();
        check("fresh_msg", msg_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hash_scheduler.md
Name: hash_scheduler

Overview:
- Message-level scheduler directly upstream of hash_engine.
- Accepts host AXI-Stream messages and latches sha_type from the first beat's tuser.
- Drives the engine's en/sha_type and forwards beats unmodified.
- Blocks new messages until the engine's digest tlast has been handshaken, with a watchdog for hung digests.

Parameters:
- S_AXIS_DATA_WIDTH, 512, data width of host stream and forwarded stream.
- S_AXIS_TUSER_WIDTH, 128, tuser width; bits [1:0] carry sha_type on the first beat.
- TIMEOUT_CYCLES, 4096, maximum cycles in WAIT_DIGEST before abort; must be >= 2.

Ports:
- axi_aclk  in  1  clock.
- axi_reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  S_AXIS_DATA_WIDTH  host message data.
- s_axis_tuser  in  S_AXIS_TUSER_WIDTH  host sideband; [1:0] = sha_type (00 224, 01 256, 10 384, 11 512).
- s_axis_tkeep  in  S_AXIS_DATA_WIDTH/8  byte enables.
- s_axis_tvalid  in  1  host valid.
- s_axis_tready  out  1  host ready.
- s_axis_tlast  in  1  last beat of message.
- m_axis_tdata/tuser/tkeep/tlast  out  same widths  forwarded beat to engine.
- m_axis_tvalid  out  1  forwarded valid.
- m_axis_tready  in  1  engine ready.
- d_axis_tvalid, d_axis_tready, d_axis_tlast  in  1 each  snooped engine digest handshake.
- sha_type  out  2  registered type to engine.
- en  out  1  engine enable.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog abort.
- msg_count  out  32  completed digests, wraps at 2^32.
- err_count  out  16  timeouts, saturates at 0xFFFF.

Behaviour:
- Reset values: state IDLE, en=0, sha_type=00, s_axis_tready=0, m_axis_tvalid=0, timeout_err=0, counters=0, watchdog=0. Reset mid-message aborts unconditionally; partial beats are not replayed.
- States: IDLE, SETUP, STREAM, WAIT_DIGEST, FLUSH.
- IDLE:
  - s_axis_tready=0, m_axis_tvalid=0, en=0.
  - If s_axis_tvalid: latch sha_type<=s_axis_tuser[1:0], go to SETUP. The beat is not consumed.
- SETUP:
  - One cycle; en=1, no transfer. Guarantees en and sha_type are stable one cycle before the first beat.
  - Go to STREAM.
- STREAM:
  - Combinational pass-through: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready; data, tuser, tkeep and tlast are wired straight through.
  - Zero added latency, no buffering; en=1; sha_type held.
  - On s_axis_tvalid & m_axis_tready & s_axis_tlast: go to WAIT_DIGEST and clear the watchdog.
  - tuser on later beats is forwarded but never re-latched.
- WAIT_DIGEST:
  - s_axis_tready=0, m_axis_tvalid=0, en=1; watchdog increments every cycle.
  - On d_axis_tvalid & d_axis_tready & d_axis_tlast: msg_count+1, go to FLUSH.
  - Else if watchdog == TIMEOUT_CYCLES-1: pulse timeout_err, err_count+1 (saturating), go to FLUSH.
  - Digest completion and watchdog expiry in the same cycle count as completion; no error.
  - Digest beats without tlast do not change state.
- FLUSH:
  - One cycle; en=0 so the engine clears; then go to IDLE.
  - A host tvalid already pending in FLUSH is seen in IDLE the following cycle.
- Throughput: minimum overhead per message is 3 cycles (IDLE detect, SETUP, FLUSH) plus engine latency.
- Single-beat message (tlast on the first beat) is legal: it is forwarded in STREAM's first cycle.
- A digest handshake snooped outside WAIT_DIGEST is ignored and not counted.
- Watchdog width is $clog2(TIMEOUT_CYCLES)+1 bits; it clears on entry to WAIT_DIGEST.
- en, sha_type, busy, timeout_err and counters are registered; m/s ready/valid in STREAM are combinational.

Decomposition:
- Shared package hash_pkg:
  - SHA type codes SHA224/SHA256/SHA384/SHA512 (2-bit).
  - Scheduler state encoding (3-bit localparams).
  - TUSER_SHA_TYPE_LSB=0.
- Optional sub-module hash_watchdog: clear, enable, expire-pulse counter parameterised on TIMEOUT_CYCLES. All other logic stays flat.

Test Plan:
- Reset then single-beat SHA-256 message (tuser[1:0]=01, tlast=1), engine ready.
  -> sha_type=01 and en=1 in SETUP; beat forwarded the next cycle.
  -> After a digest tlast handshake: msg_count=1; en=0 for exactly one cycle; busy=0 after.
- 4-beat SHA-512 message with m_axis_tready toggling 1,0,1,0...
  -> exactly 4 forwarded handshakes in order; s_axis_tready mirrors m_axis_tready.
  -> tuser changed to 00 on beat 3 does not alter sha_type (stays 11).
- Back-to-back messages, second tvalid held throughout.
  -> s_axis_tready=0 from the first tlast until the second message's STREAM.
  -> second message's sha_type latched correctly; msg_count=2.
- TIMEOUT_CYCLES=16, no digest after tlast.
  -> timeout_err pulses on the 16th WAIT_DIGEST cycle; err_count=1; msg_count=0; FLUSH then IDLE.
- TIMEOUT_CYCLES=16, digest tlast handshake exactly on the 16th cycle.
  -> msg_count=1, err_count=0, no timeout_err pulse.
- axi_reset asserted during STREAM after 2 of 4 beats.
  -> next cycle: IDLE, en=0, s_axis_tready=0, counters=0; a fresh message then completes normally.
